// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file with per-register busy scoreboard,
// optional write-to-read bypass, and a debug dump sequencer built only when GPR_DUMP_EN is defined.
module gpr_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   ra,
    output logic [NRD*DATA_W-1:0]   rd,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       wa0,
    input  logic [ADDR_W-1:0]       wa1,
    input  logic [DATA_W-1:0]       wd0,
    input  logic [DATA_W-1:0]       wd1,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic                    dump_req,
    output logic                    dump_valid,
    output logic [ADDR_W-1:0]       dump_idx,
    output logic [DATA_W-1:0]       dump_data,
    output logic                    dump_done
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              wr0_en, wr1_en, iss_en;

    // Register 0 is hardwired: qualifying every enable with a nonzero address keeps it zero and idle.
    assign wr0_en = we0 && (wa0 != '0);
    assign wr1_en = we1 && (wa1 != '0);
    assign iss_en = iss_valid && (iss_addr != '0);

    // Issue is applied last so that it overrides a same-cycle write clear.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) busy_d[wa0] = 1'b0;
        if (wr1_en) busy_d[wa1] = 1'b0;
        if (iss_en) busy_d[iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: the array is cleared on reset because software relies on every register
    // reading zero after reset; a plain RAM macro could not honour that.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wr0_en && !(wr1_en && (wa1 == wa0))) regs_q[wa0] <= wd0;
            if (wr1_en) regs_q[wa1] <= wd1;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              fwd0, fwd1;

        assign addr = ra[k*ADDR_W +: ADDR_W];
        assign fwd1 = (BYPASS != 0) && wr1_en && (wa1 == addr);
        assign fwd0 = (BYPASS != 0) && wr0_en && (wa0 == addr);
        assign rd[k*DATA_W +: DATA_W] = fwd1 ? wd1 : (fwd0 ? wd0 : regs_q[addr]);
        assign rd_busy[k] = busy_q[addr] && !(fwd0 || fwd1);
    end

`ifdef GPR_DUMP_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } dump_state_e;

    dump_state_e       state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              valid_q, done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dump_req) begin
                        state_q <= S_RUN;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (idx_q == {ADDR_W{1'b1}}) begin
                        state_q <= S_DONE;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Beat data is the stored value; same-cycle writes land after the beat.
    assign dump_valid = valid_q;
    assign dump_idx   = idx_q;
    assign dump_done  = done_q;
    assign dump_data  = valid_q ? regs_q[idx_q] : '0;
`else
    logic unused_dump_req;

    assign unused_dump_req = dump_req;
    assign dump_valid      = 1'b0;
    assign dump_idx        = '0;
    assign dump_data       = '0;
    assign dump_done       = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench for gpr_file_mp: bypass and non-bypass instances share stimulus;
// the dump sequence is exercised when GPR_DUMP_EN is defined, otherwise its outputs must stay 0.
module tb_gpr_file_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  ra = '0;
    logic        we0 = 1'b0, we1 = 1'b0, iss_valid = 1'b0, dump_req = 1'b0;
    logic [4:0]  wa0 = '0, wa1 = '0, iss_addr = '0;
    logic [31:0] wd0 = '0, wd1 = '0;

    logic [63:0] rd_b, rd_nb;
    logic [1:0]  bz_b, bz_nb;
    logic        dv_b, dd_b, dv_nb, dd_nb;
    logic [4:0]  di_b, di_nb;
    logic [31:0] ddat_b, ddat_nb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rd_busy(bz_b),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .dump_req(dump_req),
        .dump_valid(dv_b), .dump_idx(di_b), .dump_data(ddat_b), .dump_done(dd_b)
    );

    gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .rd_busy(bz_nb),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .dump_req(dump_req),
        .dump_valid(dv_nb), .dump_idx(di_nb), .dump_data(ddat_nb), .dump_done(dd_nb)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] x_rd0;
        logic [31:0] x_rd1;
        logic [1:0]  x_bz;
        logic [31:0] x_nb_rd0;
        logic        x_nb_bz0;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic is, input logic [4:0] ia, input logic [4:0] r0,
                       input logic [4:0] r1, input logic [31:0] x0, input logic [31:0] x1,
                       input logic [1:0] xbz, input logic [31:0] xn0, input logic xnbz);
        vec_t v;
        v = '{w0, a0, d0, w1, a1, d1, is, ia, r0, r1, x0, x1, xbz, xn0, xnbz};
        vecs.push_back(v);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            check({tag, "_rd_b"}, rd_b[31:0] | rd_b[63:32], 32'h0);
            check({tag, "_bz_b"}, {30'h0, bz_b}, 32'h0);
            check({tag, "_rd_nb"}, rd_nb[31:0] | rd_nb[63:32], 32'h0);
            check({tag, "_bz_nb"}, {30'h0, bz_nb}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t e;
        int   seen;

        //   we0 wa0 wd0           we1 wa1 wd1           iss ia  ra0 ra1  rd0 rd1 bz nb_rd0 nb_bz0
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 31, 32'h0, 32'h0, 2'b00, 32'h0, 0);
        add(1, 0,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  0,  0, 32'h0, 32'h0, 2'b00, 32'h0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  1, 32'h0, 32'h0, 2'b00, 32'h0, 0);
        add(1, 5,  32'h11111111, 1, 5,  32'h22222222, 0, 0,  5,  5, 32'h22222222, 32'h22222222, 2'b00, 32'h0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  0, 32'h22222222, 32'h0, 2'b00, 32'h22222222, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  7,  5, 32'h0, 32'h22222222, 2'b00, 32'h0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  7, 32'h0, 32'h0, 2'b11, 32'h0, 1);
        add(1, 7,  32'hA5,       0, 0,  32'h0,        0, 0,  7,  3, 32'hA5, 32'h0, 2'b00, 32'h0, 1);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  7, 32'hA5, 32'hA5, 2'b00, 32'hA5, 0);
        add(0, 0,  32'h0,        1, 7,  32'hB6,       1, 7,  7,  7, 32'hB6, 32'hB6, 2'b00, 32'hA5, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  7, 32'hB6, 32'hB6, 2'b11, 32'hB6, 1);
        add(0, 0,  32'h0,        1, 3,  32'h1234,     1, 0,  3,  0, 32'h1234, 32'h0, 2'b00, 32'h0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  3,  7, 32'h1234, 32'hB6, 2'b10, 32'h1234, 0);
        add(1, 1,  32'h1,        1, 31, 32'h1F,       0, 0,  1, 31, 32'h1, 32'h1F, 2'b00, 32'h0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 31, 32'h0, 32'h1F, 2'b00, 32'h0, 0);
        add(1, 7,  32'hC7,       1, 7,  32'hD8,       0, 0,  7,  1, 32'hD8, 32'h1, 2'b00, 32'hB6, 1);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  1, 32'hD8, 32'h1, 2'b00, 32'hD8, 0);

        #12 reset = 1'b0;
        @(posedge clk); #1;
        read_all_zero("reset");

        foreach (vecs[i]) begin
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
            iss_valid = vecs[i].iss; iss_addr = vecs[i].ia;
            ra = {vecs[i].ra1, vecs[i].ra0};
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("v%0d_rd0", i), rd_b[31:0], e.x_rd0);
            check($sformatf("v%0d_rd1", i), rd_b[63:32], e.x_rd1);
            check($sformatf("v%0d_busy", i), {30'h0, bz_b}, {30'h0, e.x_bz});
            check($sformatf("v%0d_nb_rd0", i), rd_nb[31:0], e.x_nb_rd0);
            check($sformatf("v%0d_nb_busy0", i), {31'h0, bz_nb[0]}, {31'h0, e.x_nb_bz0});
            @(posedge clk); #1;
        end
        we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;

`ifdef GPR_DUMP_EN
        begin
            logic [31:0] exp_mem [32];
            int          w;
            for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
            exp_mem[1] = 32'h1; exp_mem[3] = 32'h1234; exp_mem[5] = 32'h22222222;
            exp_mem[7] = 32'hD8; exp_mem[31] = 32'h1F;

            check("dump_idle_valid", {31'h0, dv_b}, 32'h0);
            dump_req = 1'b1;
            @(posedge clk); #1;
            dump_req = 1'b0;
            w = 0;
            while (!dv_b && w < 4) begin
                @(posedge clk); #1;
                w++;
            end
            check("dump_start", {31'h0, dv_b}, 32'h1);
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                check($sformatf("beat%0d_valid", i), {31'h0, dv_b}, 32'h1);
                check($sformatf("beat%0d_idx", i), {27'h0, di_b}, 32'(i));
                check($sformatf("beat%0d_data", i), ddat_b, exp_mem[i]);
                check($sformatf("beat%0d_done", i), {31'h0, dd_b}, 32'h0);
                @(posedge clk); #1;
                dump_req = (i == 4);
            end
            @(negedge clk);
            check("dump_done_pulse", {31'h0, dd_b}, 32'h1);
            check("dump_done_valid", {31'h0, dv_b}, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            check("dump_done_once", {31'h0, dd_b}, 32'h0);
            check("dump_no_restart", {31'h0, dv_b}, 32'h0);

            dump_req = 1'b1;
            @(posedge clk); #1;
            dump_req = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("abort_at_idx", {27'h0, di_b}, 32'd10);
            check("abort_valid_pre", {31'h0, dv_b}, 32'h1);
        end
`else
        seen = 0;
        dump_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dv_b || dd_b || di_b != 5'd0 || ddat_b != 32'h0) seen++;
            @(posedge clk); #1;
            dump_req = 1'b0;
        end
        check("dump_disabled_outputs", 32'(seen), 32'h0);
        @(negedge clk);
`endif

        #1 reset = 1'b1;
        #1;
        check("reset_valid", {31'h0, dv_b}, 32'h0);
        check("reset_done", {31'h0, dd_b}, 32'h0);
        check("reset_idx", {27'h0, di_b}, 32'h0);
        check("reset_data", ddat_b, 32'h0);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dd_b || dv_b || dd_nb || dv_nb) seen++;
        end
        check("no_done_after_abort", 32'(seen), 32'h0);
        read_all_zero("abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_file_mp.md
# gpr_file_mp

Parametrised multi-port general-purpose register file with a per-register busy scoreboard, for the pipelined CPU datapath. It sits between decode (read, issue) and writeback (write). It provides NRD combinational read ports, two prioritised write ports, optional same-cycle write-to-read bypass, and a dump sequencer that streams register contents for debug.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREGS = 2**ADDR_W registers
- NRD, 2, number of read ports
- BYPASS, 1, 1 = a read returns write data committing in the same cycle; 0 = a read returns the stored value
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ra  in  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd  out  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NRD  busy bit of each read address
- we0, we1  in  1  write enables; port 1 has priority
- wa0, wa1  in  ADDR_W  write addresses
- wd0, wd1  in  DATA_W  write data
- iss_valid  in  1  marks iss_addr busy (destination of an issued instruction)
- iss_addr  in  ADDR_W  destination to mark busy
- dump_req  in  1  starts a dump (only with GPR_DUMP_EN)
- dump_valid  out  1  dump beat valid
- dump_idx  out  ADDR_W  register index of the beat
- dump_data  out  DATA_W  register value of the beat
- dump_done  out  1  one-cycle pulse after the last beat

## Operation
- Reset clears all registers, all busy bits, and the dump FSM (IDLE). dump_valid, dump_done, dump_idx, and dump_data are 0.
- Register 0 always reads 0 and is never busy. Writes to it and issues to it are ignored.
- Write: on the clk edge, weN && waN != 0 stores wdN into regfile[waN] and clears busy[waN].
- If we0 and we1 target the same nonzero address, wd1 is stored and wd0 is dropped.
- Issue: on the clk edge, iss_valid && iss_addr != 0 sets busy[iss_addr].
  - If an issue and a write hit the same address in one cycle, the set wins and the bit stays busy.
- Read: rd[k] = regfile[ra[k]].
  - With BYPASS=1, a matching write is forwarded instead (we1 match first, then we0), and rd_busy[k] reads 0 for that address.
  - With BYPASS=0, neither rd nor rd_busy sees same-cycle writes.
- Dump FSM states:
  - IDLE: dump_req goes to RUN with idx=0.
  - RUN: each cycle dump_valid=1, dump_idx=idx, dump_data=regfile[idx] (stored value, no bypass); idx increments; after idx=NREGS-1 go to DONE.
  - DONE: dump_done=1 for one cycle, then IDLE.
  - dump_req is ignored outside IDLE.
- Writes proceed normally during a dump. A beat shows the value stored before that cycle's edge.

## Timing
- Read and rd_busy paths are combinational, with zero latency.
- Writes and issues are visible to stored reads on the cycle after the edge.
- A dump occupies NREGS beat cycles plus one DONE cycle. The first beat is in the cycle after the dump_req edge.
- Asserting reset mid-dump aborts it immediately. No dump_done is generated.

## Configuration
- GPR_DUMP_EN defined: the dump FSM and dump outputs are functional.
- GPR_DUMP_EN undefined: the FSM is not built. dump_valid, dump_done, dump_idx, and dump_data are tied to 0, and dump_req is ignored. Register, scoreboard, and bypass behaviour is identical in both builds.

## Test plan
- Reset, then read every address on both ports -> all rd=0, rd_busy=0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- we0 (r5, 0x11111111) and we1 (r5, 0x22222222) in the same cycle -> r5=0x22222222 next cycle. Same-cycle read of r5 with BYPASS=1 -> 0x22222222.
- Issue r7 -> rd_busy=1 on reading r7. Write r7=0xA5 two cycles later -> rd_busy=0 and rd=0xA5. Issue r7 and write r7 in the same cycle -> busy stays 1.
- BYPASS=0: write r3=0x1234 while ra0=3 -> rd0 shows the old value in that cycle and 0x1234 the next cycle.
- GPR_DUMP_EN with r1=1, r31=0x1F; pulse dump_req -> 32 beats with idx 0..31 and the matching data, then dump_done for exactly one cycle. A second dump_req mid-dump has no effect.
- Reset asserted at beat 10 -> dump_valid=0 immediately, no dump_done, all registers read 0.
